// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes and the bundled control-word type.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI: is_legal = 1'b1;
            default:                  is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_out_decode.sv
// Moore output decode for the multicycle controller; only FETCH, BRANCH and
// MEM_WRITE look at live inputs (mem_ready / zero) within the same cycle.
module control_out_decode
    import mips_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_ADD;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = 2'b01;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = 2'b11;
                ctrl_o.illegal_op = ~is_legal(opcode_i);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.pc_source  = 2'b01;
                ctrl_o.pc_en      = zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source  = 2'b10;
                ctrl_o.pc_en      = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                case (opcode_i)
                    OP_ANDI: ctrl_o.alu_op = ALU_AND;
                    OP_ORI:  ctrl_o.alu_op = ALU_OR;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register, opcode latch and next-state
// logic; output decode lives in control_out_decode and is blanked during reset.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    ctrl_t      ctrl_dec, ctrl;

    // DECODE sees the live opcode; every later state works from the latched copy.
    assign opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                    OP_RTYPE:                  state_d = S_R_EXEC;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_I_EXEC;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    control_out_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_d),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_dec)
    );

    // Reset silences every output immediately so an in-flight access cannot write.
    assign ctrl  = rst ? '0 : ctrl_dec;
    assign state = rst ? 4'd0 : state_q;

    assign pc_en      = ctrl.pc_en;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_source  = ctrl.pc_source;
    assign alu_op     = ctrl.alu_op;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-computed
// per-cycle output words, the monitor pops and compares them mid-cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b111111;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JUNK = 6'b111111;

    // Flag masks in {pc_en,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a} order
    localparam logic [8:0] F_PCEN = 9'b100000000;
    localparam logic [8:0] F_IORD = 9'b010000000;
    localparam logic [8:0] F_MRD  = 9'b001000000;
    localparam logic [8:0] F_MWR  = 9'b000100000;
    localparam logic [8:0] F_IRW  = 9'b000010000;
    localparam logic [8:0] F_M2R  = 9'b000001000;
    localparam logic [8:0] F_RDST = 9'b000000100;
    localparam logic [8:0] F_RWR  = 9'b000000010;
    localparam logic [8:0] F_SRCA = 9'b000000001;

    typedef struct {
        string       name;
        logic [22:0] exp;
    } exp_t;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;

    logic [22:0] zeroV, fetchRdy, fetchWait, decodeOk, memAddr, memRd, memWr;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] v(input logic [3:0] st, input logic [8:0] f,
                                      input logic [1:0] srcB, input logic [1:0] pcSrc,
                                      input logic [3:0] aop, input logic done, input logic ill);
        v = {st, f, srcB, pcSrc, aop, done, ill};
    endfunction

    task automatic applyStimulus(input string name, input logic [5:0] op, input logic z,
                                 input logic mr, input logic r, input logic [22:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        rst       = r;
        e.name    = name;
        e.exp     = exp;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e, input logic [22:0] act);
        compared++;
        if (act !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%b required=%b", e.name, act, e.exp);
        end
    endtask

    // Monitor: one expected word per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e, {state, pc_en, i_or_d, mem_read, mem_write, ir_write,
                                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                                pc_source, alu_op, instr_done, illegal_op});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        zeroV     = '0;
        fetchRdy  = v(4'd0, F_MRD | F_IRW | F_PCEN, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b0);
        fetchWait = v(4'd0, F_MRD, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b0);
        decodeOk  = v(4'd1, 9'd0, 2'b11, 2'b00, 4'b0000, 1'b0, 1'b0);
        memAddr   = v(4'd2, F_SRCA, 2'b10, 2'b00, 4'b0000, 1'b0, 1'b0);
        memRd     = v(4'd3, F_MRD | F_IORD, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);
        memWr     = v(4'd5, F_MWR | F_IORD, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0);

        applyStimulus("reset0", JUNK, 1'b0, 1'b0, 1'b1, zeroV);
        applyStimulus("reset1", JUNK, 1'b0, 1'b1, 1'b1, zeroV);

        // lw with memory always ready; opcode scrambled after DECODE
        applyStimulus("lw_fetch",  LW,   1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("lw_decode", LW,   1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("lw_addr",   JUNK, 1'b0, 1'b1, 1'b0, memAddr);
        applyStimulus("lw_read",   JUNK, 1'b0, 1'b1, 1'b0, memRd);
        applyStimulus("lw_wb",     JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd4, F_M2R | F_RWR, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));

        // sw with a fetch wait and two MEM_WRITE wait states
        applyStimulus("sw_fetch_wait", SW,   1'b0, 1'b0, 1'b0, fetchWait);
        applyStimulus("sw_fetch",      SW,   1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("sw_decode",     SW,   1'b0, 1'b0, 1'b0, decodeOk);
        applyStimulus("sw_addr",       JUNK, 1'b0, 1'b0, 1'b0, memAddr);
        applyStimulus("sw_write_w0",   JUNK, 1'b0, 1'b0, 1'b0, memWr);
        applyStimulus("sw_write_w1",   JUNK, 1'b0, 1'b0, 1'b0, memWr);
        applyStimulus("sw_write_done", JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd5, F_MWR | F_IORD, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));

        // beq taken, then not taken
        applyStimulus("beq1_fetch",  BEQ,  1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("beq1_decode", BEQ,  1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("beq_taken",   JUNK, 1'b1, 1'b1, 1'b0,
                      v(4'd8, F_PCEN | F_SRCA, 2'b00, 2'b01, 4'b0001, 1'b1, 1'b0));
        applyStimulus("beq2_fetch",  BEQ,  1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("beq2_decode", BEQ,  1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("beq_not",     JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd8, F_SRCA, 2'b00, 2'b01, 4'b0001, 1'b1, 1'b0));

        // R-type
        applyStimulus("r_fetch",  RT,   1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("r_decode", RT,   1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("r_exec",   JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd6, F_SRCA, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0));
        applyStimulus("r_wb",     JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd7, F_RDST | F_RWR, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));

        // andi and ori
        applyStimulus("andi_fetch",  ANDI, 1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("andi_decode", ANDI, 1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("andi_exec",   JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd10, F_SRCA, 2'b10, 2'b00, 4'b0011, 1'b0, 1'b0));
        applyStimulus("andi_wb",     JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd11, F_RWR, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));
        applyStimulus("ori_fetch",   ORI,  1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("ori_decode",  ORI,  1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("ori_exec",    JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd10, F_SRCA, 2'b10, 2'b00, 4'b0100, 1'b0, 1'b0));
        applyStimulus("ori_wb",      JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd11, F_RWR, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0));

        // jump
        applyStimulus("j_fetch",  J,    1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("j_decode", J,    1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("j_jump",   JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd9, F_PCEN, 2'b00, 2'b10, 4'b0000, 1'b1, 1'b0));

        // illegal opcode returns straight to FETCH
        applyStimulus("ill_fetch",  JUNK, 1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("ill_decode", JUNK, 1'b0, 1'b1, 1'b0,
                      v(4'd1, 9'd0, 2'b11, 2'b00, 4'b0000, 1'b0, 1'b1));

        // lw interrupted by reset while waiting in MEM_READ
        applyStimulus("ill_next_fetch", LW,   1'b0, 1'b1, 1'b0, fetchRdy);
        applyStimulus("rlw_decode",     LW,   1'b0, 1'b1, 1'b0, decodeOk);
        applyStimulus("rlw_addr",       JUNK, 1'b0, 1'b0, 1'b0, memAddr);
        applyStimulus("rlw_read_wait",  JUNK, 1'b0, 1'b0, 1'b0, memRd);
        applyStimulus("rlw_rst0",       JUNK, 1'b0, 1'b1, 1'b1, zeroV);
        applyStimulus("rlw_rst1",       JUNK, 1'b0, 1'b1, 1'b1, zeroV);
        applyStimulus("post_rst_fetch0", JUNK, 1'b0, 1'b0, 1'b0, fetchWait);
        applyStimulus("post_rst_fetch1", JUNK, 1'b0, 1'b0, 1'b0, fetchWait);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: MULTICYCLE_CONTROL

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port: zero  in  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready  in  1  memory access completes this cycle.
REQ-006 SHALL have 1-bit outputs: pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-007 SHALL have outputs: alu_src_b (2; 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and pc_source (2; 00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 SHALL have output: alu_op  out  4  code to ALU_CONTROL: ADD 0000, SUB 0001, FUNCT 0010, AND 0011, OR 0100.
REQ-009 SHALL have outputs: state  out  4  current state (debug); instr_done  out  1; illegal_op  out  1.

Function
REQ-010 SHALL implement a Moore FSM; encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
REQ-011 SHALL decode opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101; all other opcodes are illegal.
REQ-012 SHALL latch opcode into an internal register in DECODE and use the latched value in every later state of the instruction.
REQ-013 Transitions SHALL be:
- FETCH->DECODE on mem_ready, else hold.
- DECODE-> lw/sw MEM_ADDR, R R_EXEC, beq BRANCH, j JUMP, addi/andi/ori I_EXEC, illegal FETCH.
- MEM_ADDR-> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ->MEM_WB on mem_ready, else hold.
- MEM_WRITE->FETCH on mem_ready, else hold.
- R_EXEC->R_WB; I_EXEC->I_WB.
- MEM_WB, R_WB, I_WB, BRANCH, JUMP -> FETCH.
REQ-014 Outputs not listed for a state SHALL be 0; alu_op defaults to ADD.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, ir_write=pc_en=mem_ready.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD.
REQ-018 MEM_READ: mem_read=1, i_or_d=1. MEM_WRITE: mem_write=1, i_or_d=1.
REQ-019 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. R_WB: reg_write=1, reg_dst=1.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_en=zero (same-cycle combinational).
REQ-022 JUMP: pc_source=10, pc_en=1.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10; alu_op ADD (addi), AND (andi), OR (ori). I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-024 instr_done SHALL be 1 for one cycle in MEM_WB, R_WB, I_WB, BRANCH, JUMP, and in MEM_WRITE when mem_ready=1.
REQ-025 illegal_op SHALL be 1 exactly in the DECODE cycle of an illegal opcode; no register or memory write SHALL occur for it.
REQ-026 mem_ready SHALL be ignored outside FETCH, MEM_READ, MEM_WRITE; each wait-state cycle SHALL repeat that state's outputs unchanged, with pc_en and ir_write held 0.

Reset
REQ-027 rst=1 at a rising edge SHALL set state to FETCH and the latched opcode to 000000.
REQ-028 While rst=1, all outputs SHALL be forced to 0 (state output reads 0); this SHALL take effect in any state, abandoning the instruction with no write.
REQ-029 First cycle after rst deasserts SHALL be FETCH with REQ-015 outputs.

Structure
REQ-030 State encodings, opcode constants and alu_op codes SHALL live in shared package MIPS_PKG, also used by ALU_CONTROL's instantiator.
REQ-031 Single sub-module CONTROL_OUT_DECODE (combinational: state, latched opcode, zero, mem_ready -> outputs) SHALL be used; the state register and next-state logic stay in MULTICYCLE_CONTROL.

Verification
REQ-032 lw, mem_ready=1 throughout -> states 0,1,2,3,4; reg_write and mem_to_reg=1 in cycle 5; instr_done once.
REQ-033 sw, mem_ready low 2 cycles in MEM_WRITE -> MEM_WRITE held 3 cycles with mem_write=1, then FETCH; no reg_write at any time.
REQ-034 beq with zero=1 -> pc_en=1, pc_source=01, alu_op=0001 in BRANCH; repeat with zero=0 -> pc_en=0.
REQ-035 R-type, then andi -> alu_op 0010 in R_EXEC with reg_dst=1; alu_op 0011 in I_EXEC with reg_dst=0.
REQ-036 opcode 111111 -> illegal_op=1 in DECODE, next state FETCH, no writes.
REQ-037 rst asserted in MEM_READ -> all outputs 0 while asserted, FETCH after release, no MEM_WB.
